// File: rtl/cr_channel_allocator_if.sv
// rtl/cr_channel_allocator_if.sv - sense/request/lease bundle for the cognitive-radio channel allocator
// Ports (signals):
//   pu_active   master->slave  primary-user occupancy per channel
//   su_req      master->slave  level request per secondary user
//   su_grant    slave->master  SU currently holds a channel
//   ch_busy     slave->master  channel leased to an SU
//   ch_owner    slave->master  owner index per channel, slice [c*OW +: OW]
//   evict       slave->master  one-cycle pulse, SU lost its lease to a returning PU
//   frame_start slave->master  one-cycle pulse on slot 0 of each frame
//   slot_cnt    slave->master  current bit-slot of the frame
interface cr_channel_allocator_if #(
    parameter int N_CH      = 3,
    parameter int N_SU      = 6,
    parameter int FRAME_LEN = 32
);
    localparam int OW = $clog2(N_SU);
    localparam int SW = $clog2(FRAME_LEN);

    logic [N_CH-1:0]    pu_active;
    logic [N_SU-1:0]    su_req;
    logic [N_SU-1:0]    su_grant;
    logic [N_CH-1:0]    ch_busy;
    logic [N_CH*OW-1:0] ch_owner;
    logic [N_SU-1:0]    evict;
    logic               frame_start;
    logic [SW-1:0]      slot_cnt;

    modport master (
        output pu_active, su_req,
        input  su_grant, ch_busy, ch_owner, evict, frame_start, slot_cnt
    );

    modport slave (
        input  pu_active, su_req,
        output su_grant, ch_busy, ch_owner, evict, frame_start, slot_cnt
    );
endinterface

// File: rtl/cr_channel_allocator.sv
// rtl/cr_channel_allocator.sv - round-robin leasing of idle licensed channels to secondary users
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  cr_channel_allocator_if.slave (pu_active, su_req in; grants, leases, owners, evict, frame timing out)
// Optional feature macro: CR_GUARD_EN (per-channel PU-idle guard counters, parameter GUARD)
module cr_channel_allocator #(
    parameter int N_CH      = 3,
    parameter int N_SU      = 6,
    parameter int FRAME_LEN = 32
`ifdef CR_GUARD_EN
    ,
    parameter int GUARD     = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    cr_channel_allocator_if.slave  bus
);
    localparam int OW = $clog2(N_SU);
    localparam int SW = $clog2(FRAME_LEN);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, SENSE, ALLOC, RUN} state_t;

    state_t             state_q;
    logic [N_CH-1:0]    pu_q;
    logic [OW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      alloc_c_q;
    logic [SW-1:0]      slot_q;
    logic               frame_start_q;
    logic [N_CH-1:0]    busy_q, busy_d;
    logic [N_SU-1:0]    grant_q, grant_d;
    logic [N_CH*OW-1:0] owner_q, owner_d;
    logic [N_SU-1:0]    evict_q, evict_d;
    logic [N_CH-1:0]    eligible;

    logic [OW-1:0]      own;
    logic               pu_ret;
    logic               hit;
    logic [OW-1:0]      hit_su;
    int                 idx;

`ifdef CR_GUARD_EN
    localparam int GW = $clog2(GUARD + 1);
    logic [N_CH-1:0][GW-1:0] guard_q;

    // Idle counters run in every state so a PU that left just before SENSE is still too fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (bus.pu_active[c])
                    guard_q[c] <= '0;
                else if (guard_q[c] != GW'(GUARD))
                    guard_q[c] <= guard_q[c] + 1'b1;
            end
        end
    end

    always_comb begin
        eligible = '0;
        for (int c = 0; c < N_CH; c++)
            eligible[c] = (guard_q[c] == GW'(GUARD)) && !pu_q[c];
    end
`else
    assign eligible = ~pu_q;
`endif

    // Lease bookkeeping: releases first, then at most one grant for the channel under ALLOC.
    // A release only touches busy channels and their (granted) owners, while a grant only
    // touches an idle channel and an ungranted SU, so the two never collide on a bit.
    always_comb begin
        busy_d  = busy_q;
        grant_d = grant_q;
        owner_d = owner_q;
        evict_d = '0;
        rr_d    = rr_q;
        own     = '0;
        pu_ret  = 1'b0;
        hit     = 1'b0;
        hit_su  = '0;
        idx     = 0;

        for (int c = 0; c < N_CH; c++) begin
            own    = owner_q[c*OW +: OW];
            pu_ret = bus.pu_active[c] && (state_q != IDLE);
            if (busy_q[c] && (pu_ret || !bus.su_req[own])) begin
                busy_d[c]    = 1'b0;
                grant_d[own] = 1'b0;
                evict_d[own] = pu_ret;      // PU return wins over a simultaneous drop
            end
        end

        if (state_q == ALLOC && eligible[alloc_c_q] && !busy_q[alloc_c_q]) begin
            // Scan backwards so the candidate closest to rr_q is the last one written.
            for (int k = N_SU - 1; k >= 0; k--) begin
                idx = int'(rr_q) + k;
                if (idx >= N_SU)
                    idx = idx - N_SU;
                if (bus.su_req[idx] && !grant_q[idx]) begin
                    hit    = 1'b1;
                    hit_su = OW'(idx);
                end
            end
            if (hit) begin
                busy_d[alloc_c_q]              = 1'b1;
                owner_d[alloc_c_q*OW +: OW]    = hit_su;
                grant_d[hit_su]                = 1'b1;
                rr_d = (hit_su == OW'(N_SU - 1)) ? '0 : hit_su + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pu_q          <= '0;
            rr_q          <= '0;
            alloc_c_q     <= '0;
            slot_q        <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= '0;
            grant_q       <= '0;
            owner_q       <= '0;
            evict_q       <= '0;
        end else begin
            busy_q        <= busy_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            evict_q       <= evict_d;
            rr_q          <= rr_d;
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.su_req || |busy_q)
                        state_q <= SENSE;
                end
                SENSE: begin
                    pu_q      <= bus.pu_active;
                    alloc_c_q <= '0;
                    state_q   <= ALLOC;
                end
                ALLOC: begin
                    if (alloc_c_q == CW'(N_CH - 1)) begin
                        state_q       <= RUN;
                        frame_start_q <= 1'b1;
                        slot_q        <= '0;
                    end else begin
                        alloc_c_q <= alloc_c_q + 1'b1;
                    end
                end
                RUN: begin
                    if (slot_q == SW'(FRAME_LEN - 1)) begin
                        slot_q  <= '0;
                        // Look at post-release leases so a frame that just lost its last one can idle.
                        state_q <= (bus.su_req == '0 && busy_d == '0) ? IDLE : SENSE;
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.su_grant    = grant_q;
    assign bus.ch_busy     = busy_q;
    assign bus.ch_owner    = owner_q;
    assign bus.evict       = evict_q;
    assign bus.frame_start = frame_start_q;
    assign bus.slot_cnt    = slot_q;
endmodule
